adc_spi_sampler: RTL and testbench
==================================

Name: adc_spi_sampler

Overview:
- Front-end stage that feeds the Kalman filter's measurement port.
- Periodically reads a 16-bit two's-complement sample from an external SPI ADC, using SPI mode 0, MSB first.
- Subtracts a calibration offset with saturation.
- Presents the result on z/z_valid: a one-cycle valid pulse per sample, no back-pressure.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK phase (high or low); legal range 2..255.
- SAMPLE_PERIOD, 10000: clk cycles between conversion starts; must be >= 34*CLK_DIV+2 to avoid overrun.
- ADC_OFFSET, 16'sd0: signed offset subtracted from every raw sample.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  allow periodic conversions
- adc_miso  in  1  ADC serial data (externally synchronous to clk, stable around SCLK rise)
- adc_cs_n  out  1  ADC chip select, active low, registered
- adc_sclk  out  1  SPI clock, idle low, registered
- z  out  16  signed conditioned measurement, held between updates
- z_valid  out  1  one-cycle pulse, z is new
- sat  out  1  one-cycle pulse coincident with z_valid when the result was clamped
- overrun  out  1  one-cycle pulse when a tick arrives while a conversion is in progress
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, any state): adc_cs_n=1, adc_sclk=0, z=0, z_valid=0, sat=0, overrun=0, busy=0. FSM goes to IDLE, period counter goes to 0, shift register is cleared.
- Tick generator:
  - enable=0: counter forced to 0, no tick.
  - enable=1 and count==0: tick=1, count reloads SAMPLE_PERIOD-1.
  - Otherwise the counter decrements.
  - The first tick therefore fires on the first enabled cycle.
- FSM states: IDLE, SETUP, SHIFT, DONE, QUIET. A tick seen at cycle t0 is defined below.
  - IDLE: cs_n=1, sclk=0. A tick moves to SETUP.
  - SETUP: t0+1 .. t0+CLK_DIV. cs_n=0, sclk=0.
  - SHIFT: 16 bits, each 2*CLK_DIV cycles. High phase first (sclk=1 for CLK_DIV cycles), then low phase (sclk=0 for CLK_DIV cycles).
    - adc_miso is captured into the shift register at the clk edge that drives sclk 0->1, i.e. once per bit. MSB arrives first.
    - A bit counter of 0..15 advances at the end of each low phase.
    - After bit 0's low phase the FSM moves to DONE.
  - DONE: exactly one cycle, at t0+33*CLK_DIV+1.
    - cs_n=1.
    - z and sat are registered from the result; z_valid=1.
  - QUIET: CLK_DIV-1 cycles with cs_n=1 (minimum CS high time), then IDLE.
- Arithmetic:
  - diff is the 17-bit sign-extended raw minus the 17-bit sign-extended ADC_OFFSET.
  - diff > 32767 gives z=32767, sat=1.
  - diff < -32768 gives z=-32768, sat=1.
  - Otherwise z=diff[15:0], sat=0.
- Overrun: a tick in any state other than IDLE is dropped and overrun pulses in the same cycle as the tick. The conversion in progress is unaffected.
- enable falling mid-conversion: the current conversion completes and z_valid is still issued. No new ticks occur.
- z holds its value until the next DONE. z_valid is never asserted on two consecutive cycles.
- The total busy span per conversion is 34*CLK_DIV cycles, measured from SETUP entry to IDLE return.

Decomposition:
- Shared package kalman_pkg:
  - typedef sample_t = logic signed [15:0]
  - localparam SAMPLE_W=16
  - function sat17to16(logic signed [16:0]), returning a clamped sample_t plus a clamp flag. This function is reused by the filter and later stages.
- Sub-module sample_tick_gen, parameter PERIOD; ports clk, reset_n, enable, tick. It is the period counter only.
- The FSM, shift register and offset/saturation logic stay in adc_spi_sampler.

Test Plan:
- Basic capture: CLK_DIV=4, offset 0, ADC model drives 0x1234, enable asserted at t0 -> z_valid single pulse at t0+133, z=0x1234 (4660), sat=0. Exactly 16 SCLK rising edges inside cs_n low, each high phase 4 cycles.
- Offset saturation: ADC_OFFSET=100, model drives 0x8001 (-32767) -> z=-32768, sat=1. With ADC_OFFSET=-100 and model 0x7FF0 -> z=32767, sat=1. With ADC_OFFSET=-100 and model 0x0005 -> z=105, sat=0.
- Periodic rate: SAMPLE_PERIOD=200, enable held high for 1000 cycles -> z_valid pulses exactly 200 cycles apart, 5 pulses total, overrun never asserted.
- Overrun: SAMPLE_PERIOD=100, CLK_DIV=4 -> tick at 100 hits SHIFT and overrun pulses for 1 cycle. The conversion started at 0 still yields z_valid at 133. The next conversion starts at tick 200; z_valid pulses every 200 cycles.
- Reset mid-SHIFT: assert reset_n=0 during bit 8 -> same cycle adc_cs_n=1, adc_sclk=0, busy=0, z=0, no z_valid. After release with enable=1, the first conversion yields the correct model value.
- enable drop mid-conversion: deassert enable during SETUP -> the conversion completes with one z_valid, then no further cs_n activity for 1000 cycles.

Source files
------------

// File: rtl/kalman_pkg.sv
// rtl/kalman_pkg.sv - shared sample type, FSM states and 17-to-16 bit saturation helper
package kalman_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t value;
    logic    clamped;
  } sat_result_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_DONE,
    ST_QUIET
  } adc_state_t;

  // A 17-bit result fits in 16 bits exactly when its top two bits agree.
  function automatic sat_result_t sat17to16(input logic signed [SAMPLE_W:0] x);
    sat_result_t r;
    r.value   = x[SAMPLE_W-1:0];
    r.clamped = 1'b0;
    if (x[SAMPLE_W] != x[SAMPLE_W-1]) begin
      r.clamped = 1'b1;
      r.value   = x[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                              : {1'b0, {(SAMPLE_W-1){1'b1}}};
    end
    return r;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - conversion period counter; ticks on the first enabled cycle
module sample_tick_gen #(
  parameter int PERIOD = 10000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (count == '0) begin
      count <= RELOAD;
    end else begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/adc_spi_sampler.sv
// rtl/adc_spi_sampler.sv - periodic SPI mode-0 ADC reader with offset removal and saturation
module adc_spi_sampler
  import kalman_pkg::*;
#(
  parameter int                 CLK_DIV       = 4,
  parameter int                 SAMPLE_PERIOD = 10000,
  parameter logic signed [15:0] ADC_OFFSET    = 16'sd0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               adc_miso,
  output logic               adc_cs_n,
  output logic               adc_sclk,
  output logic signed [15:0] z,
  output logic               z_valid,
  output logic               sat,
  output logic               overrun,
  output logic               busy
);

  localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] QUIET_LAST = 8'(CLK_DIV - 2);

  adc_state_t         state, state_nxt;
  logic [7:0]         phase_cnt, phase_nxt;
  logic [3:0]         bit_cnt, bit_nxt;
  logic [15:0]        shreg;
  logic               tick;
  logic               phase_last;
  logic               capture;
  logic               cs_n_nxt;
  logic               sclk_nxt;
  logic               valid_nxt;
  logic signed [16:0] diff;
  sat_result_t        result;

  sample_tick_gen #(
    .PERIOD(SAMPLE_PERIOD)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .tick   (tick)
  );

  assign busy       = (state != ST_IDLE);
  assign overrun    = tick && busy;
  assign phase_last = (phase_cnt == PHASE_LAST);
  assign diff       = $signed({shreg[15], shreg}) - $signed({ADC_OFFSET[15], ADC_OFFSET});
  assign result     = sat17to16(diff);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      phase_cnt <= '0;
      bit_cnt   <= '0;
      adc_cs_n  <= 1'b1;
      adc_sclk  <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase_cnt <= phase_nxt;
      bit_cnt   <= bit_nxt;
      adc_cs_n  <= cs_n_nxt;
      adc_sclk  <= sclk_nxt;
    end
  end

  // Pin levels are decided for the next state so cs_n/sclk come straight from flops.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase_cnt;
    bit_nxt   = bit_cnt;
    cs_n_nxt  = 1'b1;
    sclk_nxt  = 1'b0;
    capture   = 1'b0;
    valid_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick) begin
          state_nxt = ST_SETUP;
          phase_nxt = '0;
          cs_n_nxt  = 1'b0;
        end
      end
      ST_SETUP: begin
        cs_n_nxt = 1'b0;
        if (phase_last) begin
          state_nxt = ST_SHIFT;
          phase_nxt = '0;
          bit_nxt   = 4'd15;
          sclk_nxt  = 1'b1;
          capture   = 1'b1;
        end else begin
          phase_nxt = phase_cnt + 8'd1;
        end
      end
      ST_SHIFT: begin
        cs_n_nxt = 1'b0;
        sclk_nxt = adc_sclk;
        if (!phase_last) begin
          phase_nxt = phase_cnt + 8'd1;
        end else begin
          phase_nxt = '0;
          if (adc_sclk) begin
            sclk_nxt = 1'b0;
          end else if (bit_cnt == 4'd0) begin
            state_nxt = ST_DONE;
            cs_n_nxt  = 1'b1;
            valid_nxt = 1'b1;
          end else begin
            bit_nxt  = bit_cnt - 4'd1;
            sclk_nxt = 1'b1;
            capture  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_QUIET;
        phase_nxt = '0;
      end
      ST_QUIET: begin
        if (phase_cnt == QUIET_LAST) begin
          state_nxt = ST_IDLE;
        end else begin
          phase_nxt = phase_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        phase_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg   <= '0;
      z       <= '0;
      sat     <= 1'b0;
      z_valid <= 1'b0;
    end else begin
      if (capture) begin
        shreg <= {shreg[14:0], adc_miso};
      end
      z_valid <= valid_nxt;
      sat     <= valid_nxt && result.clamped;
      if (valid_nxt) begin
        z <= result.value;
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// tb/tb_adc_spi_sampler.sv - scoreboard bench for adc_spi_sampler with three configured instances
module tb_adc_spi_sampler;

  typedef struct {
    int cyc;
    int z;
    int sat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  int   ovq_b[$];

  logic rst_a_n, rst_bc_n;
  logic en_a, en_b, en_c;
  logic miso_a, miso_b, miso_c;
  logic cs_n_a, cs_n_b, cs_n_c;
  logic sclk_a, sclk_b, sclk_c;
  logic signed [15:0] z_a, z_b, z_c;
  logic zv_a, zv_b, zv_c;
  logic sat_a, sat_b, sat_c;
  logic ovr_a, ovr_b, ovr_c;
  logic busy_a, busy_b, busy_c;
  logic [15:0] word_a, word_b, word_c;
  logic [15:0] sh_a = '0, sh_b = '0, sh_c = '0;
  logic sclk_d_a = 1'b0, sclk_d_b = 1'b0, sclk_d_c = 1'b0;

  adc_spi_sampler #(.CLK_DIV(4), .SAMPLE_PERIOD(200), .ADC_OFFSET(16'sd0)) u_a (
    .clk(clk), .reset_n(rst_a_n), .enable(en_a), .adc_miso(miso_a),
    .adc_cs_n(cs_n_a), .adc_sclk(sclk_a), .z(z_a), .z_valid(zv_a),
    .sat(sat_a), .overrun(ovr_a), .busy(busy_a));

  adc_spi_sampler #(.CLK_DIV(4), .SAMPLE_PERIOD(100), .ADC_OFFSET(16'sd100)) u_b (
    .clk(clk), .reset_n(rst_bc_n), .enable(en_b), .adc_miso(miso_b),
    .adc_cs_n(cs_n_b), .adc_sclk(sclk_b), .z(z_b), .z_valid(zv_b),
    .sat(sat_b), .overrun(ovr_b), .busy(busy_b));

  adc_spi_sampler #(.CLK_DIV(4), .SAMPLE_PERIOD(200), .ADC_OFFSET(-16'sd100)) u_c (
    .clk(clk), .reset_n(rst_bc_n), .enable(en_c), .adc_miso(miso_c),
    .adc_cs_n(cs_n_c), .adc_sclk(sclk_c), .z(z_c), .z_valid(zv_c),
    .sat(sat_c), .overrun(ovr_c), .busy(busy_c));

  // ADC models: word latched while CS is high, next bit presented after each SCLK fall.
  always @(posedge clk) begin
    sclk_d_a <= sclk_a;
    sclk_d_b <= sclk_b;
    sclk_d_c <= sclk_c;
    if (cs_n_a) sh_a <= word_a; else if (sclk_d_a && !sclk_a) sh_a <= {sh_a[14:0], 1'b0};
    if (cs_n_b) sh_b <= word_b; else if (sclk_d_b && !sclk_b) sh_b <= {sh_b[14:0], 1'b0};
    if (cs_n_c) sh_c <= word_c; else if (sclk_d_c && !sclk_c) sh_c <= {sh_c[14:0], 1'b0};
  end
  assign miso_a = sh_a[15];
  assign miso_b = sh_b[15];
  assign miso_c = sh_c[15];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic stray(input string name);
    checks++;
    $display("FAIL %s: got unexpected pulse at cycle %0d, expected none", name, cyc);
  endtask

  task automatic cmp(input string tag, input exp_t e, input int zz, input int s);
    check({tag, "_valid_cycle"}, cyc, e.cyc);
    check({tag, "_z"}, zz, e.z);
    check({tag, "_sat"}, s, e.sat);
  endtask

  task automatic push_exp(input int inst, input int c, input int zz, input int s);
    exp_t e;
    e.cyc = c;
    e.z   = zz;
    e.sat = s;
    case (inst)
      0: q_a.push_back(e);
      1: q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  int zv_cnt_a = 0;
  int cs_falls_a = 0;
  int rises_a = 0, hi_len_a = 0, hi_bad_a = 0, busy_len_a = 0;
  logic sclk_p_a = 1'b0, cs_p_a = 1'b1, busy_p_a = 1'b0;

  always @(negedge clk) begin
    if (zv_a) begin
      zv_cnt_a <= zv_cnt_a + 1;
      if (q_a.size() == 0) stray("a_z_valid");
      else cmp("a", q_a.pop_front(), z_a, sat_a);
    end
    if (sat_a && !zv_a) stray("a_sat");
    if (ovr_a) stray("a_overrun");

    if (zv_b) begin
      if (q_b.size() == 0) stray("b_z_valid");
      else cmp("b", q_b.pop_front(), z_b, sat_b);
    end
    if (sat_b && !zv_b) stray("b_sat");
    if (ovr_b) begin
      if (ovq_b.size() == 0) stray("b_overrun");
      else check("b_overrun_cycle", cyc, ovq_b.pop_front());
    end

    if (zv_c) begin
      if (q_c.size() == 0) stray("c_z_valid");
      else cmp("c", q_c.pop_front(), z_c, sat_c);
    end
    if (sat_c && !zv_c) stray("c_sat");
    if (ovr_c) stray("c_overrun");
  end

  // SPI framing and busy-span monitor for instance a; spans cut short by reset are skipped.
  always @(negedge clk) begin
    sclk_p_a <= sclk_a;
    cs_p_a   <= cs_n_a;
    busy_p_a <= busy_a;
    if (!cs_n_a && cs_p_a) cs_falls_a <= cs_falls_a + 1;
    if (!rst_a_n) begin
      rises_a    <= 0;
      hi_len_a   <= 0;
      hi_bad_a   <= 0;
      busy_len_a <= 0;
    end else begin
      if (sclk_a) hi_len_a <= hi_len_a + 1;
      else hi_len_a <= 0;
      if (sclk_a && !sclk_p_a && !cs_n_a) rises_a <= rises_a + 1;
      if (!sclk_a && sclk_p_a && hi_len_a != 4) hi_bad_a <= hi_bad_a + 1;
      if (cs_n_a && !cs_p_a) begin
        check("a_sclk_rises_in_frame", rises_a, 16);
        check("a_bad_high_phases", hi_bad_a, 0);
        rises_a  <= 0;
        hi_bad_a <= 0;
      end
      if (busy_a) busy_len_a <= busy_len_a + 1;
      if (!busy_a && busy_p_a) begin
        check("a_busy_span", busy_len_a, 136);
        busy_len_a <= 0;
      end
    end
  end

  task automatic run_a();
    int c0, zv0, falls0;
    logic [15:0] wv [5];
    int ev [5];
    wv = '{16'h1234, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001};
    ev = '{4660, -1, -32768, 32767, 1};

    en_a = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 5; k++) begin
      word_a = wv[k];
      push_exp(0, c0 + 133 + 200 * k, ev[k], 0);
      repeat (200) @(posedge clk);
      #1;
    end
    en_a = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("a_periodic_pulse_count", zv_cnt_a, 5);
    check("a_z_held", z_a, 1);

    zv0 = zv_cnt_a;
    word_a = 16'h0F0F;
    en_a = 1'b1;
    c0 = cyc;
    push_exp(0, c0 + 133, 3855, 0);
    repeat (2) @(posedge clk);
    #1;
    en_a = 1'b0;
    repeat (140) @(posedge clk);
    #1;
    falls0 = cs_falls_a;
    repeat (1000) @(posedge clk);
    #1;
    check("a_cs_quiet_after_enable_drop", cs_falls_a - falls0, 0);
    check("a_enable_drop_valids", zv_cnt_a - zv0, 1);

    word_a = 16'hA5A5;
    en_a = 1'b1;
    c0 = cyc;
    repeat (63) @(posedge clk);
    #1;
    rst_a_n = 1'b0;
    #1;
    check("a_midshift_reset_cs_n", cs_n_a, 1);
    check("a_midshift_reset_sclk", sclk_a, 0);
    check("a_midshift_reset_busy", busy_a, 0);
    check("a_midshift_reset_z", z_a, 0);
    check("a_midshift_reset_z_valid", zv_a, 0);
    word_a = 16'h5A5A;
    repeat (3) @(posedge clk);
    #1;
    rst_a_n = 1'b1;
    c0 = cyc;
    push_exp(0, c0 + 133, 23130, 0);
    repeat (150) @(posedge clk);
    #1;
    en_a = 1'b0;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic run_b();
    int c0;
    word_b = 16'h8001;
    en_b = 1'b1;
    c0 = cyc;
    push_exp(1, c0 + 133, -32768, 1);
    push_exp(1, c0 + 333, -95, 0);
    ovq_b.push_back(c0 + 100);
    ovq_b.push_back(c0 + 300);
    repeat (150) @(posedge clk);
    #1;
    word_b = 16'h0005;
    repeat (249) @(posedge clk);
    #1;
    en_b = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("b_z_held", z_b, -95);
  endtask

  task automatic run_c();
    int c0;
    word_c = 16'h7FF0;
    en_c = 1'b1;
    c0 = cyc;
    push_exp(2, c0 + 133, 32767, 1);
    push_exp(2, c0 + 333, 105, 0);
    repeat (150) @(posedge clk);
    #1;
    word_c = 16'h0005;
    repeat (249) @(posedge clk);
    #1;
    en_c = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("c_z_held", z_c, 105);
  endtask

  initial begin
    rst_a_n  = 1'b0;
    rst_bc_n = 1'b0;
    en_a = 1'b0;
    en_b = 1'b0;
    en_c = 1'b0;
    word_a = '0;
    word_b = '0;
    word_c = '0;
    repeat (3) @(posedge clk);
    #1;
    check("a_reset_cs_n", cs_n_a, 1);
    check("a_reset_sclk", sclk_a, 0);
    check("a_reset_z", z_a, 0);
    check("a_reset_z_valid", zv_a, 0);
    check("a_reset_sat", sat_a, 0);
    check("a_reset_overrun", ovr_a, 0);
    check("a_reset_busy", busy_a, 0);
    check("b_reset_cs_n", cs_n_b, 1);
    check("c_reset_busy", busy_c, 0);
    rst_a_n  = 1'b1;
    rst_bc_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    fork
      run_a();
      run_b();
      run_c();
    join
    repeat (20) @(posedge clk);
    #1;
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
    check("c_queue_drained", q_c.size(), 0);
    check("b_overrun_queue_drained", ovq_b.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
